// File: rtl/gost_pkg.sv
// gost_pkg: shared constants, widths and state encoding for the
// GOST counter-mode (gamma) controller.
package gost_pkg;

  localparam int HW = 32;

  localparam logic [HW-1:0] GOST_C1 = 32'h01010104;
  localparam logic [HW-1:0] GOST_C2 = 32'h01010101;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SYNC = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_GEN  = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    SYNC = ST_SYNC,
    RUN  = ST_RUN,
    GEN  = ST_GEN,
    HOLD = ST_HOLD
  } state_e;

endpackage

// File: rtl/gost_ctr_step.sv
// gost_ctr_step: combinational gamma counter step.
// n_i = {N2,N1} -> n_o = {N2+C1 mod 2^32-1, N1+C2 mod 2^32}.
module gost_ctr_step
  import gost_pkg::*;
(
  input  logic [2*HW-1:0] n_i,
  output logic [2*HW-1:0] n_o
);

  logic [HW:0]   s2;
  logic [HW-1:0] n2_nxt;
  logic [HW-1:0] n1_nxt;

  always_comb begin
    s2     = {1'b0, n_i[2*HW-1:HW]} + {1'b0, GOST_C1};
    // end-around carry folds the 2^32 overflow back in
    n2_nxt = s2[HW-1:0] + HW'(s2[HW]);
    n1_nxt = n_i[HW-1:0] + GOST_C2;
    n_o    = {n2_nxt, n1_nxt};
  end

endmodule

// File: rtl/gost_gamma_ctrl.sv
// gost_gamma_ctrl: counter-mode controller around an external GOST core.
// Ports: CLK/RST, IV load, DIN/DOUT valid-ready streams, CORE_IN/CORE_OUT.
module gost_gamma_ctrl
  import gost_pkg::*;
#(
  parameter int CORE_LAT = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [63:0]   IV,
  input  logic          IV_VALID,
  output logic          SYNCED,
  input  logic [63:0]   DIN,
  input  logic          DIN_VALID,
  output logic          DIN_READY,
  output logic [63:0]   DOUT,
  output logic          DOUT_VALID,
  input  logic          DOUT_READY,
  output logic [63:0]   CORE_IN,
  input  logic [63:0]   CORE_OUT
);

  localparam int CW =
    (CORE_LAT > 0) ? $clog2(CORE_LAT + 1) : 1;
  localparam logic [CW-1:0] LAT_C = CW'(CORE_LAT);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] n_q, n_d;
  logic [63:0] core_in_q, core_in_d;
  logic [63:0] dout_q, dout_d;
  logic [63:0] din_q, din_d;
  logic        synced_q, synced_d;
  logic        dout_valid_q, dout_valid_d;
  logic        din_ready;
  logic [63:0] n_nxt;

  gost_ctr_step u_step (
    .n_i (n_q),
    .n_o (n_nxt)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    core_in_d    = core_in_q;
    dout_d       = dout_q;
    din_d        = din_q;
    synced_d     = synced_q;
    dout_valid_d = dout_valid_q;
    din_ready    = (state_q == RUN) && !IV_VALID;
    unique case (state_q)
      IDLE: begin
        if (IV_VALID) begin
          core_in_d = IV;
          cnt_d     = '0;
          state_d   = SYNC;
        end
      end
      SYNC: begin
        if (cnt_q == LAT_C) begin
          n_d      = CORE_OUT;
          synced_d = 1'b1;
          state_d  = RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        // a resync request wins over a pending data block
        if (IV_VALID) begin
          core_in_d = IV;
          cnt_d     = '0;
          synced_d  = 1'b0;
          state_d   = SYNC;
        end else if (DIN_VALID) begin
          din_d     = DIN;
          core_in_d = n_nxt;
          n_d       = n_nxt;
          cnt_d     = '0;
          state_d   = GEN;
        end
      end
      GEN: begin
        if (cnt_q == LAT_C) begin
          dout_d       = din_q ^ CORE_OUT;
          dout_valid_d = 1'b1;
          state_d      = HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (DOUT_READY) begin
          dout_valid_d = 1'b0;
          state_d      = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      n_q          <= '0;
      core_in_q    <= '0;
      dout_q       <= '0;
      din_q        <= '0;
      synced_q     <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      core_in_q    <= core_in_d;
      dout_q       <= dout_d;
      din_q        <= din_d;
      synced_q     <= synced_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign SYNCED     = synced_q;
  assign DIN_READY  = din_ready;
  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;
  assign CORE_IN    = core_in_q;

endmodule

// File: tb/tb_gost_gamma_ctrl.sv
// tb_gost_gamma_ctrl: scoreboard bench, identity core (lat 0)
// and 3-stage delayed identity core (lat 3).
module tb_gost_gamma_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0][63:0] iv;
  logic [1:0][63:0] din;
  logic [1:0]       iv_valid;
  logic [1:0]       din_valid;
  logic [1:0]       dout_ready;

  logic        synced0, din_ready0, dout_valid0;
  logic [63:0] dout0, core_in0, core_out0;
  logic        synced1, din_ready1, dout_valid1;
  logic [63:0] dout1, core_in1, core_out1;
  logic [63:0] p1, p2, p3;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] mn[2];

  always #5 clk = ~clk;

  assign core_out0 = core_in0;

  always_ff @(posedge clk) begin
    p1 <= core_in1;
    p2 <= p1;
    p3 <= p2;
  end
  assign core_out1 = p3;

  gost_gamma_ctrl #(.CORE_LAT(0)) dut0 (
    .CLK        (clk),
    .RST        (rst),
    .IV         (iv[0]),
    .IV_VALID   (iv_valid[0]),
    .SYNCED     (synced0),
    .DIN        (din[0]),
    .DIN_VALID  (din_valid[0]),
    .DIN_READY  (din_ready0),
    .DOUT       (dout0),
    .DOUT_VALID (dout_valid0),
    .DOUT_READY (dout_ready[0]),
    .CORE_IN    (core_in0),
    .CORE_OUT   (core_out0)
  );

  gost_gamma_ctrl #(.CORE_LAT(3)) dut1 (
    .CLK        (clk),
    .RST        (rst),
    .IV         (iv[1]),
    .IV_VALID   (iv_valid[1]),
    .SYNCED     (synced1),
    .DIN        (din[1]),
    .DIN_VALID  (din_valid[1]),
    .DIN_READY  (din_ready1),
    .DOUT       (dout1),
    .DOUT_VALID (dout_valid1),
    .DOUT_READY (dout_ready[1]),
    .CORE_IN    (core_in1),
    .CORE_OUT   (core_out1)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mstep(input logic [63:0] n);
    logic [63:0] a;
    logic [31:0] lo;
    a = {32'h0, n[63:32]} + 64'h0000_0000_0101_0104;
    if (a > 64'h0000_0000_FFFF_FFFF)
      a = a - 64'h0000_0000_FFFF_FFFF;
    lo = n[31:0] + 32'h0101_0101;
    return {a[31:0], lo};
  endfunction

  function automatic logic g_synced(input int d);
    return (d == 0) ? synced0 : synced1;
  endfunction
  function automatic logic g_rdy(input int d);
    return (d == 0) ? din_ready0 : din_ready1;
  endfunction
  function automatic logic g_vld(input int d);
    return (d == 0) ? dout_valid0 : dout_valid1;
  endfunction
  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid0 && dout_ready[0]) begin
        if (q0.size() == 0) chk("unexp0", 64'(q0.size()), 64'd1);
        else chk("dout0", dout0, q0.pop_front());
      end
      if (dout_valid1 && dout_ready[1]) begin
        if (q1.size() == 0) chk("unexp1", 64'(q1.size()), 64'd1);
        else chk("dout1", dout1, q1.pop_front());
      end
    end
  end

  task automatic load_iv(input int d, input logic [63:0] val);
    int lat;
    lat = (d == 0) ? 0 : 3;
    @(posedge clk); #1;
    iv[d] = val;
    iv_valid[d] = 1'b1;
    @(posedge clk); #1;
    iv_valid[d] = 1'b0;
    chk("sync_lo", 64'(g_synced(d)), 64'd0);
    repeat (lat + 1) @(posedge clk);
    #1;
    chk("sync_hi", 64'(g_synced(d)), 64'd1);
    mn[d] = val;
  endtask

  task automatic send_block(input int d, input logic [63:0] data,
                            input bit meas);
    int lat;
    bit ok;
    bit seen;
    lat  = (d == 0) ? 0 : 3;
    ok   = 1'b0;
    seen = 1'b0;
    @(posedge clk); #1;
    din[d] = data;
    din_valid[d] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (g_rdy(d)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_to", 64'd0, 64'd1);
      din_valid[d] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    din_valid[d] = 1'b0;
    mn[d] = mstep(mn[d]);
    if (d == 0) q0.push_back(data ^ mn[d]);
    else q1.push_back(data ^ mn[d]);
    if (meas) begin
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk); #1;
        if (g_vld(d)) begin
          chk("latency", 64'(i), 64'(lat + 1));
          seen = 1'b1;
          break;
        end
      end
      if (!seen) chk("lat_to", 64'd0, 64'd1);
    end
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 50; i++) begin
      if (qsize(d) == 0) break;
      @(negedge clk);
    end
    chk("drain", 64'(qsize(d)), 64'd0);
  endtask

  initial begin
    logic [63:0] e;
    iv         = '0;
    din        = '0;
    iv_valid   = '0;
    din_valid  = '0;
    dout_ready = 2'b11;
    mn[0]      = '0;
    mn[1]      = '0;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_synced", 64'(synced0), 64'd0);
    chk("rst_dvalid", 64'(dout_valid0), 64'd0);
    chk("rst_drdy", 64'(din_ready0), 64'd0);
    chk("rst_dout", dout0, 64'd0);
    chk("rst_corein", core_in0, 64'd0);
    #2 rst = 1'b0;

    load_iv(0, 64'd0);
    send_block(0, 64'd0, 1'b1);
    chk("t1_dout", dout0, 64'h01010104_01010101);
    drain(0);

    load_iv(0, 64'hFFFFFFFD_FFFFFFFF);
    send_block(0, 64'd0, 1'b1);
    chk("t2_dout", dout0, 64'h01010102_01010100);
    drain(0);

    for (int k = 0; k < 4; k++) begin
      send_block(0, {$urandom, $urandom}, 1'b1);
      drain(0);
    end

    @(posedge clk); #1;
    dout_ready[0] = 1'b0;
    send_block(0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1);
    e = 64'hA5A5_5A5A_0F0F_F0F0 ^ mn[0];
    din[0] = 64'h1234_5678_9ABC_DEF0;
    din_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(dout_valid0), 64'd1);
      chk("bp_dout", dout0, e);
      chk("bp_drdy", 64'(din_ready0), 64'd0);
    end
    @(posedge clk); #1;
    din_valid[0]  = 1'b0;
    dout_ready[0] = 1'b1;
    send_block(0, 64'h1234_5678_9ABC_DEF0, 1'b1);
    drain(0);

    @(posedge clk); #1;
    iv[0]        = 64'h0000_0001_0000_0002;
    iv_valid[0]  = 1'b1;
    din[0]       = 64'h0000_0000_0000_FFFF;
    din_valid[0] = 1'b1;
    @(negedge clk);
    chk("pri_drdy", 64'(din_ready0), 64'd0);
    @(posedge clk); #1;
    iv_valid[0]  = 1'b0;
    din_valid[0] = 1'b0;
    chk("pri_sync_lo", 64'(synced0), 64'd0);
    @(posedge clk); #1;
    chk("pri_sync_hi", 64'(synced0), 64'd1);
    mn[0] = 64'h0000_0001_0000_0002;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("pri_nodout", 64'(dout_valid0), 64'd0);
    end
    send_block(0, 64'd0, 1'b1);
    drain(0);

    send_block(0, 64'h0000_0000_DEAD_BEEF, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rg_synced", 64'(synced0), 64'd0);
    chk("rg_dvalid", 64'(dout_valid0), 64'd0);
    chk("rg_drdy", 64'(din_ready0), 64'd0);
    chk("rg_dout", dout0, 64'd0);
    chk("rg_corein", core_in0, 64'd0);
    q0.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    load_iv(0, 64'd0);
    send_block(0, 64'd0, 1'b1);
    chk("t5_dout", dout0, 64'h01010104_01010101);
    drain(0);

    load_iv(1, 64'd0);
    send_block(1, 64'd0, 1'b1);
    chk("t6a_dout", dout1, 64'h01010104_01010101);
    drain(1);
    load_iv(1, 64'hFFFFFFFD_FFFFFFFF);
    send_block(1, 64'd0, 1'b1);
    chk("t6b_dout", dout1, 64'h01010102_01010100);
    drain(1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
